// File: rtl/melody_pkg.sv
// Shared types and constants for the melody game engine.
package melody_pkg;

  localparam int unsigned NOTE_W  = 6;
  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned IDX_W   = 3;  // note index within a melody, up to 8 notes
  localparam int unsigned PCNT_W  = 4;  // press count, 0..8 inclusive

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(3);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(3);

  localparam logic [NOTE_W-1:0] NOTE_C = 6'b000001;
  localparam logic [NOTE_W-1:0] NOTE_D = 6'b000010;
  localparam logic [NOTE_W-1:0] NOTE_E = 6'b000100;
  localparam logic [NOTE_W-1:0] NOTE_F = 6'b001000;
  localparam logic [NOTE_W-1:0] NOTE_G = 6'b010000;
  localparam logic [NOTE_W-1:0] NOTE_A = 6'b100000;

  typedef enum logic [1:0] {P_IDLE, P_NOTE, P_GAP, P_DONE} play_state_t;
  typedef enum logic [1:0] {I_IDLE, I_ARMED, I_RELEASE, I_DONE} cap_state_t;

  // Eight notes of one melody, element 0 plays first.
  typedef logic [7:0][NOTE_W-1:0] melody_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic is_onehot(input logic [NOTE_W-1:0] v);
    return (v != '0) && ((v & (v - NOTE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/melody_if.sv
// Control/status bundle between the game controller and the melody engine.
interface melody_if;
  import melody_pkg::*;

  logic                play;
  logic                stone_reset;
  logic                auto_reset;
  logic                level_one_active;
  logic                check_score_enable;
  logic                next_level;
  logic                hard_reset;
  logic [NOTE_W-1:0]   user_input;
  logic [NOTE_W-1:0]   note_out;
  logic                stone_isdone;
  logic                ih_isdone;
  logic                win;
  logic [LIVES_W-1:0]  lives;
  logic [LEVEL_W-1:0]  level;

  modport master (
    output play, stone_reset, auto_reset, level_one_active, check_score_enable,
           next_level, hard_reset, user_input,
    input  note_out, stone_isdone, ih_isdone, win, lives, level
  );

  modport slave (
    input  play, stone_reset, auto_reset, level_one_active, check_score_enable,
           next_level, hard_reset, user_input,
    output note_out, stone_isdone, ih_isdone, win, lives, level
  );
endinterface

// File: rtl/melody_rom.sv
// Melody table: (level, index) -> one-hot note, purely combinational.
module melody_rom
  import melody_pkg::*;
(
  input  logic [LEVEL_W-1:0] level,
  input  logic [IDX_W-1:0]   idx,
  output logic [NOTE_W-1:0]  note
);

  melody_t row;

  // Concatenations list index 7 first, index 0 last.
  always_comb begin
    row = '0;
    case (level)
      2'd0: row = {NOTE_F, NOTE_G, NOTE_A, NOTE_G, NOTE_F, NOTE_E, NOTE_D, NOTE_C};
      2'd1: row = {NOTE_D, NOTE_E, NOTE_F, NOTE_G, NOTE_G, NOTE_F, NOTE_E, NOTE_E};
      2'd2: row = {NOTE_A, NOTE_G, NOTE_F, NOTE_E, NOTE_D, NOTE_C, NOTE_E, NOTE_G};
      default: row = {NOTE_E, NOTE_D, NOTE_C, NOTE_D, NOTE_E, NOTE_F, NOTE_G, NOTE_A};
    endcase
  end

  assign note = row[idx];

endmodule

// File: rtl/melody_engine.sv
// Melody game engine: plays a per-level melody, captures the player's key
// presses, judges them and tracks lives and level.
// Optional key debounce is built when MELODY_DEBOUNCE_EN is defined.
module melody_engine
  import melody_pkg::*;
#(
  parameter int unsigned NOTE_TICKS     = 25000000,
  parameter int unsigned GAP_TICKS      = 5000000,
  parameter int unsigned SEQ_LEN        = 4,
  parameter int unsigned DEBOUNCE_TICKS = 500000
) (
  input  logic    clock,
  input  logic    resetn,
  melody_if.slave bus
);

  localparam int unsigned TICK_W = $clog2(max3(NOTE_TICKS, GAP_TICKS, DEBOUNCE_TICKS) + 1);
  localparam logic [TICK_W-1:0] NOTE_LAST = TICK_W'(NOTE_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SEQ_LEN - 1);
  localparam logic [PCNT_W-1:0] PCNT_FULL = PCNT_W'(SEQ_LEN);

  play_state_t         play_state;
  logic [IDX_W-1:0]    idx;
  logic [TICK_W-1:0]   tick;
  logic [NOTE_W-1:0]   note_q;
  logic                stone_q;

  cap_state_t          cap_state;
  logic [PCNT_W-1:0]   press_cnt;
  logic                match;
  logic                ih_q;

  logic                win_q;
  logic [LIVES_W-1:0]  lives_q;
  logic [LEVEL_W-1:0]  level_q;

  logic [IDX_W-1:0]    play_addr;
  logic [NOTE_W-1:0]   play_note;
  logic [NOTE_W-1:0]   cap_note;
  logic [NOTE_W-1:0]   key;
  logic                kill;

  assign kill = !resetn || bus.hard_reset;

  // A restart reads note 0; otherwise the lookup prefetches the note after the current gap.
  assign play_addr = bus.play ? '0 : idx + IDX_W'(1);

  melody_rom u_rom_play (
    .level (level_q),
    .idx   (play_addr),
    .note  (play_note)
  );

  melody_rom u_rom_cap (
    .level (level_q),
    .idx   (press_cnt[IDX_W-1:0]),
    .note  (cap_note)
  );

`ifdef MELODY_DEBOUNCE_EN
  localparam logic [TICK_W-1:0] DEB_FULL = TICK_W'(DEBOUNCE_TICKS);

  logic [NOTE_W-1:0] key_last;
  logic [NOTE_W-1:0] key_db;
  logic [TICK_W-1:0] run;
  logic [TICK_W-1:0] run_next;

  // Length of the current run of identical samples, saturating at the window.
  always_comb begin
    run_next = TICK_W'(1);
    if (bus.user_input == key_last) begin
      run_next = (run == DEB_FULL) ? run : run + TICK_W'(1);
    end
  end

  // Debounced key value follows the input only once it has been stable for the window.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      key_last <= '0;
      key_db   <= '0;
      run      <= '0;
    end else begin
      key_last <= bus.user_input;
      run      <= run_next;
      if (run_next == DEB_FULL) key_db <= bus.user_input;
    end
  end

  assign key = key_db;
`else
  assign key = bus.user_input;
`endif

  // Playback FSM: note / gap timing and the done flag.
  always_ff @(posedge clock) begin
    if (kill) begin
      play_state <= P_IDLE;
      idx        <= '0;
      tick       <= '0;
      note_q     <= '0;
      stone_q    <= 1'b0;
    end else if (bus.play) begin
      play_state <= P_NOTE;
      idx        <= '0;
      tick       <= '0;
      note_q     <= play_note;
      stone_q    <= 1'b0;
    end else begin
      case (play_state)
        P_NOTE: begin
          if (tick == NOTE_LAST) begin
            tick       <= '0;
            note_q     <= '0;
            play_state <= P_GAP;
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        P_GAP: begin
          if (tick == GAP_LAST) begin
            tick <= '0;
            if (idx == IDX_LAST) begin
              play_state <= P_DONE;
              stone_q    <= 1'b1;
            end else begin
              idx        <= idx + IDX_W'(1);
              note_q     <= play_note;
              play_state <= P_NOTE;
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        P_DONE: begin
          if (bus.stone_reset) begin
            play_state <= P_IDLE;
            stone_q    <= 1'b0;
          end
        end
        default: begin
          note_q  <= '0;
          stone_q <= 1'b0;
        end
      endcase
    end
  end

  // Capture FSM: one count per press/release pair, compared against the melody.
  always_ff @(posedge clock) begin
    if (kill || bus.auto_reset) begin
      cap_state <= I_IDLE;
      press_cnt <= '0;
      match     <= 1'b0;
      ih_q      <= 1'b0;
    end else begin
      case (cap_state)
        I_IDLE: begin
          if (bus.level_one_active) begin
            cap_state <= I_ARMED;
            press_cnt <= '0;
            match     <= 1'b1;
          end
        end
        I_ARMED: begin
          if (key != '0) begin
            press_cnt <= press_cnt + PCNT_W'(1);
            match     <= match && is_onehot(key) && (key == cap_note);
            cap_state <= I_RELEASE;
          end
        end
        I_RELEASE: begin
          if (key == '0) begin
            if (press_cnt == PCNT_FULL) begin
              cap_state <= I_DONE;
              ih_q      <= 1'b1;
            end else begin
              cap_state <= I_ARMED;
            end
          end
        end
        default: ih_q <= 1'b1;
      endcase
    end
  end

  // Scoring: judging first, level advance last so a simultaneous advance clears win.
  always_ff @(posedge clock) begin
    if (kill) begin
      win_q   <= 1'b0;
      lives_q <= LIVES_INIT;
      level_q <= '0;
    end else begin
      if (bus.check_score_enable) begin
        win_q <= (cap_state == I_DONE) && match;
        if (!((cap_state == I_DONE) && match) && (lives_q != '0)) begin
          lives_q <= lives_q - LIVES_W'(1);
        end
      end
      if (bus.next_level) begin
        win_q <= 1'b0;
        if (level_q != LEVEL_MAX) level_q <= level_q + LEVEL_W'(1);
      end
    end
  end

  assign bus.note_out     = note_q;
  assign bus.stone_isdone = stone_q;
  assign bus.ih_isdone    = ih_q;
  assign bus.win          = win_q;
  assign bus.lives        = lives_q;
  assign bus.level        = level_q;

endmodule

// File: tb/tb_melody_engine.sv
// Directed bench for melody_engine with short note/gap timing.
module tb_melody_engine;

  localparam int unsigned NT = 4;
  localparam int unsigned GT = 2;
  localparam int unsigned SL = 4;
  localparam int unsigned DT = 3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  // Level 0 melody, first four notes: C D E F.
  logic [5:0] mel0 [4] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000};

  melody_if bus();

  melody_engine #(
    .NOTE_TICKS     (NT),
    .GAP_TICKS      (GT),
    .SEQ_LEN        (SL),
    .DEBOUNCE_TICKS (DT)
  ) u_dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press_key(input logic [5:0] k);
    bus.user_input = k;
    step(5);
    bus.user_input = '0;
    step(5);
  endtask

  task automatic arm();
    bus.level_one_active = 1'b1;
    step();
    bus.level_one_active = 1'b0;
  endtask

  task automatic score();
    bus.check_score_enable = 1'b1;
    step();
    bus.check_score_enable = 1'b0;
  endtask

  task automatic clear_capture();
    bus.auto_reset = 1'b1;
    step();
    bus.auto_reset = 1'b0;
  endtask

  task automatic test_reset();
    bit bad;
    bus.play = 0; bus.stone_reset = 0; bus.auto_reset = 0; bus.level_one_active = 0;
    bus.check_score_enable = 0; bus.next_level = 0; bus.hard_reset = 0; bus.user_input = '0;
    resetn = 1'b0;
    step(3);
    vectors++; if (bus.note_out !== 6'd0) begin errors++; $display("FAIL reset_note: got %b want 000000", bus.note_out); end
    vectors++; if (bus.stone_isdone !== 1'b0) begin errors++; $display("FAIL reset_stone: got %b want 0", bus.stone_isdone); end
    vectors++; if (bus.ih_isdone !== 1'b0) begin errors++; $display("FAIL reset_ih: got %b want 0", bus.ih_isdone); end
    vectors++; if (bus.win !== 1'b0) begin errors++; $display("FAIL reset_win: got %b want 0", bus.win); end
    vectors++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d want 3", bus.lives); end
    vectors++; if (bus.level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    resetn = 1'b1;
    step();
    // reset in the middle of a note abandons playback
    bus.play = 1'b1; step(); bus.play = 1'b0;
    step(2);
    vectors++; if (bus.note_out !== mel0[0]) begin errors++; $display("FAIL abandon_pre: got %b want %b", bus.note_out, mel0[0]); end
    resetn = 1'b0;
    step();
    vectors++; if (bus.note_out !== 6'd0) begin errors++; $display("FAIL abandon_note: got %b want 000000", bus.note_out); end
    step();
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.stone_isdone !== 1'b0 || bus.note_out !== 6'd0) bad = 1;
    end
    vectors++; if (bad !== 1'b0) begin errors++; $display("FAIL abandon_quiet: activity after reset got %b want 0", bad); end
  endtask

  task automatic test_playback();
    logic [5:0] en;
    logic       es;
    bus.play = 1'b1; step(); bus.play = 1'b0;
    for (int k = 0; k < 25; k++) begin
      en = (k < 24 && (k % 6) < 4) ? mel0[k / 6] : 6'd0;
      es = (k == 24);
      vectors++; if (bus.note_out !== en) begin errors++; $display("FAIL play_note[%0d]: got %b want %b", k, bus.note_out, en); end
      vectors++; if (bus.stone_isdone !== es) begin errors++; $display("FAIL play_stone[%0d]: got %b want %b", k, bus.stone_isdone, es); end
      if (k < 24) step();
    end
    step(3);
    vectors++; if (bus.stone_isdone !== 1'b1) begin errors++; $display("FAIL stone_hold: got %b want 1", bus.stone_isdone); end
    bus.stone_reset = 1'b1; step(); bus.stone_reset = 1'b0;
    vectors++; if (bus.stone_isdone !== 1'b0) begin errors++; $display("FAIL stone_clear: got %b want 0", bus.stone_isdone); end
  endtask

  task automatic test_restart();
    logic [5:0] en;
    int n;
    bus.play = 1'b1; step(); bus.play = 1'b0;
    step(16);
    vectors++; if (bus.note_out !== 6'd0) begin errors++; $display("FAIL restart_gap: got %b want 000000", bus.note_out); end
    bus.play = 1'b1; step(); bus.play = 1'b0;
    for (int k = 0; k < 7; k++) begin
      en = (k < 4) ? mel0[0] : (k < 6) ? 6'd0 : mel0[1];
      vectors++; if (bus.note_out !== en) begin errors++; $display("FAIL restart_note[%0d]: got %b want %b", k, bus.note_out, en); end
      if (k < 6) step();
    end
    n = 0;
    while (bus.stone_isdone !== 1'b1 && n < 40) begin step(); n++; end
    vectors++; if (bus.stone_isdone !== 1'b1) begin errors++; $display("FAIL restart_done: timeout, got %b want 1", bus.stone_isdone); end
    bus.stone_reset = 1'b1; step(); bus.stone_reset = 1'b0;
  endtask

  task automatic test_capture_correct();
    // first key is already down when capture is armed
    bus.user_input = mel0[0];
    step(4);
    arm();
    step(3);
    bus.user_input = '0;
    step(5);
    press_key(mel0[1]);
    press_key(mel0[2]);
    vectors++; if (bus.ih_isdone !== 1'b0) begin errors++; $display("FAIL cap_early: got %b want 0", bus.ih_isdone); end
    press_key(mel0[3]);
    vectors++; if (bus.ih_isdone !== 1'b1) begin errors++; $display("FAIL cap_done: got %b want 1", bus.ih_isdone); end
    score();
    vectors++; if (bus.win !== 1'b1) begin errors++; $display("FAIL cap_win: got %b want 1", bus.win); end
    vectors++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL cap_lives: got %0d want 3", bus.lives); end
    clear_capture();
    vectors++; if (bus.ih_isdone !== 1'b0) begin errors++; $display("FAIL cap_clear: got %b want 0", bus.ih_isdone); end
  endtask

  task automatic test_capture_wrong();
    arm();
    press_key(6'b000010);
    for (int i = 1; i < 4; i++) press_key(mel0[i]);
    vectors++; if (bus.ih_isdone !== 1'b1) begin errors++; $display("FAIL wrong_done: got %b want 1", bus.ih_isdone); end
    score();
    vectors++; if (bus.win !== 1'b0) begin errors++; $display("FAIL wrong_win: got %b want 0", bus.win); end
    vectors++; if (bus.lives !== 2'd2) begin errors++; $display("FAIL wrong_lives: got %0d want 2", bus.lives); end
    clear_capture();
    arm();
    press_key(6'b000011);
    for (int i = 1; i < 4; i++) press_key(mel0[i]);
    score();
    vectors++; if (bus.lives !== 2'd1) begin errors++; $display("FAIL chord_lives: got %0d want 1", bus.lives); end
    clear_capture();
    score();
    vectors++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL idle_lives: got %0d want 0", bus.lives); end
    score();
    vectors++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL sat_lives: got %0d want 0", bus.lives); end
    bus.hard_reset = 1'b1; step(); bus.hard_reset = 1'b0;
    vectors++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL hard_lives: got %0d want 3", bus.lives); end
  endtask

`ifdef MELODY_DEBOUNCE_EN
  task automatic test_debounce();
    arm();
    bus.user_input = 6'b100000;
    step(2);
    bus.user_input = '0;
    step(5);
    for (int i = 0; i < 3; i++) press_key(mel0[i]);
    vectors++; if (bus.ih_isdone !== 1'b0) begin errors++; $display("FAIL glitch_count: got %b want 0", bus.ih_isdone); end
    bus.user_input = mel0[3];
    step(3);
    bus.user_input = '0;
    step(5);
    vectors++; if (bus.ih_isdone !== 1'b1) begin errors++; $display("FAIL deb_done: got %b want 1", bus.ih_isdone); end
    score();
    vectors++; if (bus.win !== 1'b1) begin errors++; $display("FAIL deb_win: got %b want 1", bus.win); end
    clear_capture();
  endtask
`else
  task automatic test_no_debounce();
    arm();
    for (int i = 0; i < 4; i++) begin
      bus.user_input = mel0[i]; step();
      bus.user_input = '0;      step();
    end
    vectors++; if (bus.ih_isdone !== 1'b1) begin errors++; $display("FAIL fast_done: got %b want 1", bus.ih_isdone); end
    score();
    vectors++; if (bus.win !== 1'b1) begin errors++; $display("FAIL fast_win: got %b want 1", bus.win); end
    clear_capture();
  endtask
`endif

  task automatic test_levels();
    bit bad;
    arm();
    for (int i = 0; i < 4; i++) press_key(mel0[i]);
    bus.check_score_enable = 1'b1; bus.next_level = 1'b1; step();
    bus.check_score_enable = 1'b0; bus.next_level = 1'b0;
    vectors++; if (bus.win !== 1'b0) begin errors++; $display("FAIL both_win: got %b want 0", bus.win); end
    vectors++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL both_lives: got %0d want 3", bus.lives); end
    vectors++; if (bus.level !== 2'd1) begin errors++; $display("FAIL level1: got %0d want 1", bus.level); end
    clear_capture();
    bus.check_score_enable = 1'b1; bus.next_level = 1'b1; step();
    bus.check_score_enable = 1'b0; bus.next_level = 1'b0;
    vectors++; if (bus.lives !== 2'd2) begin errors++; $display("FAIL both_fail_lives: got %0d want 2", bus.lives); end
    vectors++; if (bus.level !== 2'd2) begin errors++; $display("FAIL level2: got %0d want 2", bus.level); end
    bus.next_level = 1'b1; step(); bus.next_level = 1'b0;
    vectors++; if (bus.level !== 2'd3) begin errors++; $display("FAIL level3: got %0d want 3", bus.level); end
    bus.next_level = 1'b1; step(); bus.next_level = 1'b0;
    vectors++; if (bus.level !== 2'd3) begin errors++; $display("FAIL level_sat: got %0d want 3", bus.level); end
    bus.hard_reset = 1'b1; bus.play = 1'b1; bus.next_level = 1'b1;
    bus.check_score_enable = 1'b1; bus.level_one_active = 1'b1;
    step();
    bus.hard_reset = 1'b0; bus.play = 1'b0; bus.next_level = 1'b0;
    bus.check_score_enable = 1'b0; bus.level_one_active = 1'b0;
    vectors++; if (bus.level !== 2'd0) begin errors++; $display("FAIL hr_level: got %0d want 0", bus.level); end
    vectors++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL hr_lives: got %0d want 3", bus.lives); end
    vectors++; if (bus.win !== 1'b0) begin errors++; $display("FAIL hr_win: got %b want 0", bus.win); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.note_out !== 6'd0 || bus.stone_isdone !== 1'b0) bad = 1;
      step();
    end
    vectors++; if (bad !== 1'b0) begin errors++; $display("FAIL hr_noplay: activity got %b want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_restart();
    test_capture_correct();
    test_capture_wrong();
`ifdef MELODY_DEBOUNCE_EN
    test_debounce();
`else
    test_no_debounce();
`endif
    test_levels();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
